// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and constants for the register-file write arbiter.
`default_nettype none

package regfile_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 1 << ADDR_W;
    localparam int ZERO_REG = 0;

    // "reg" is a keyword, so the destination field is named wreg
    typedef struct packed {
        logic [ADDR_W-1:0] wreg;
        logic [DATA_W-1:0] data;
    } wr_req_t;

    typedef enum logic {
        GRANT_REQ0 = 1'b0,
        GRANT_REQ1 = 1'b1
    } grant_t;

    function automatic logic [NUM_REGS-1:0] decode_reg(input logic [ADDR_W-1:0] r);
        logic [NUM_REGS-1:0] d;
        d    = '0;
        d[r] = 1'b1;
        return d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_write_arbiter_if.sv
// Bundle of the two requester handshakes and the register-file write port.
`default_nettype none

interface regfile_write_arbiter_if;
    import regfile_pkg::*;

    logic                req0Valid;
    logic                req0Ready;
    logic [ADDR_W-1:0]   req0Reg;
    logic [DATA_W-1:0]   req0Data;
    logic                req1Valid;
    logic                req1Ready;
    logic [ADDR_W-1:0]   req1Reg;
    logic [DATA_W-1:0]   req1Data;
    logic                regWrite;
    logic [ADDR_W-1:0]   writeReg;
    logic [DATA_W-1:0]   writeData;
    logic [NUM_REGS-1:0] pendingMask;
    logic                busy;

    modport master (
        output req0Valid, req0Reg, req0Data,
        output req1Valid, req1Reg, req1Data,
        input  req0Ready, req1Ready,
        input  regWrite, writeReg, writeData, pendingMask, busy
    );

    modport slave (
        input  req0Valid, req0Reg, req0Data,
        input  req1Valid, req1Reg, req1Data,
        output req0Ready, req1Ready,
        output regWrite, writeReg, writeData, pendingMask, busy
    );

endinterface

`default_nettype wire

// File: rtl/regfile_write_fifo.sv
// Per-requester write FIFO; exposes every slot and its valid bit for the pending mask.
`default_nettype none

module regfile_write_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  push,
    input  wire wr_req_t               push_data,
    input  wire logic                  pop,
    output wr_req_t                    head,
    output logic                       full,
    output logic                       empty,
    output wr_req_t [DEPTH-1:0]        entries,
    output logic    [DEPTH-1:0]        valid
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Occupancy is tracked per slot, so full/empty fall out of the pointer slots
    assign head  = entries[rd_ptr];
    assign full  = valid[wr_ptr];
    assign empty = !valid[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            valid   <= '0;
            entries <= '0;
        end else begin
            if (push) begin
                entries[wr_ptr] <= push_data;
                valid[wr_ptr]   <= 1'b1;
                wr_ptr          <= next_ptr(wr_ptr);
            end
            if (pop) begin
                valid[rd_ptr] <= 1'b0;
                rd_ptr        <= next_ptr(rd_ptr);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbitration of two buffered writers onto the single register-file write port.
`default_nettype none

module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    regfile_write_arbiter_if.slave  bus
);

    wr_req_t                    head0, head1;
    wr_req_t                    push_data0, push_data1;
    wr_req_t [FIFO_DEPTH-1:0]   entries0, entries1;
    logic    [FIFO_DEPTH-1:0]   valid0, valid1;
    logic                       full0, full1;
    logic                       empty0, empty1;
    logic                       push0, push1;
    logic                       grant0, grant1;
    grant_t                     last_grant;
    logic                       reg_write;
    logic [ADDR_W-1:0]          write_reg;
    logic [DATA_W-1:0]          write_data;
    logic [NUM_REGS-1:0]        pending_mask;

    // Full is the pre-pop state, so a pop never opens ready in the same cycle
    assign bus.req0Ready = rst_n && !full0;
    assign bus.req1Ready = rst_n && !full1;

    // Writes to register 0 are handshaken but dropped
    assign push0 = bus.req0Valid && bus.req0Ready && (bus.req0Reg != ADDR_W'(ZERO_REG));
    assign push1 = bus.req1Valid && bus.req1Ready && (bus.req1Reg != ADDR_W'(ZERO_REG));

    assign push_data0 = '{wreg: bus.req0Reg, data: bus.req0Data};
    assign push_data1 = '{wreg: bus.req1Reg, data: bus.req1Data};

    assign grant0 = !empty0 && (empty1 || (last_grant == GRANT_REQ1));
    assign grant1 = !empty1 && (empty0 || (last_grant == GRANT_REQ0));

    regfile_write_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push0),
        .push_data (push_data0),
        .pop       (grant0),
        .head      (head0),
        .full      (full0),
        .empty     (empty0),
        .entries   (entries0),
        .valid     (valid0)
    );

    regfile_write_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push1),
        .push_data (push_data1),
        .pop       (grant1),
        .head      (head1),
        .full      (full1),
        .empty     (empty1),
        .entries   (entries1),
        .valid     (valid1)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_write  <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
            last_grant <= GRANT_REQ1;
        end else begin
            reg_write <= grant0 || grant1;
            if (grant0) begin
                write_reg  <= head0.wreg;
                write_data <= head0.data;
                last_grant <= GRANT_REQ0;
            end else if (grant1) begin
                write_reg  <= head1.wreg;
                write_data <= head1.data;
                last_grant <= GRANT_REQ1;
            end
        end
    end

    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (valid0[i]) pending_mask = pending_mask | decode_reg(entries0[i].wreg);
            if (valid1[i]) pending_mask = pending_mask | decode_reg(entries1[i].wreg);
        end
        if (reg_write) pending_mask = pending_mask | decode_reg(write_reg);
    end

    assign bus.regWrite    = reg_write;
    assign bus.writeReg    = write_reg;
    assign bus.writeData   = write_data;
    assign bus.pendingMask = pending_mask;
    assign bus.busy        = !empty0 || !empty1 || reg_write;

endmodule

`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter.
`default_nettype none

module tb_regfile_write_arbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    regfile_write_arbiter_if bus ();

    regfile_write_arbiter #(.FIFO_DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    int          i0, i1;
    logic        acc0, acc1;
    logic [31:0] r0_regs [3] = '{1, 3, 5};
    logic [31:0] r1_regs [3] = '{2, 4, 6};
    logic [31:0] exp_rw  [8] = '{0, 1, 1, 1, 1, 1, 1, 0};
    logic [31:0] exp_reg [8] = '{0, 1, 2, 3, 4, 5, 6, 0};

    initial begin
        // Reset held with both requesters asserting
        bus.req0Valid = 1'b1; bus.req0Reg = 5'd7; bus.req0Data = 32'h77;
        bus.req1Valid = 1'b1; bus.req1Reg = 5'd8; bus.req1Data = 32'h88;
        tick();
        tick();
        chk("rst_regWrite", bus.regWrite, 0);
        chk("rst_writeReg", bus.writeReg, 0);
        chk("rst_mask", bus.pendingMask, 0);
        chk("rst_ready0", bus.req0Ready, 0);
        chk("rst_ready1", bus.req1Ready, 0);
        chk("rst_busy", bus.busy, 0);

        // Release; single req0 write {1, 0xA} taken on the first edge
        rst_n = 1'b1;
        bus.req1Valid = 1'b0;
        bus.req0Reg = 5'd1; bus.req0Data = 32'hA;
        #1;
        chk("rel_ready0", bus.req0Ready, 1);
        chk("rel_ready1", bus.req1Ready, 1);
        tick();
        bus.req0Valid = 1'b0;
        chk("single_mask_n", bus.pendingMask, 32'h2);
        chk("single_rw_n", bus.regWrite, 0);
        chk("single_busy_n", bus.busy, 1);
        tick();
        chk("single_rw", bus.regWrite, 1);
        chk("single_reg", bus.writeReg, 1);
        chk("single_data", bus.writeData, 32'hA);
        chk("single_mask", bus.pendingMask, 32'h2);
        tick();
        chk("single_rw_off", bus.regWrite, 0);
        chk("single_mask_off", bus.pendingMask, 0);
        chk("single_reg_hold", bus.writeReg, 1);
        chk("single_busy_off", bus.busy, 0);

        // Lone req1 write leaves lastGrant on requester 1
        bus.req1Valid = 1'b1; bus.req1Reg = 5'd9; bus.req1Data = 32'h99;
        tick();
        bus.req1Valid = 1'b0;
        tick();
        chk("r1_rw", bus.regWrite, 1);
        chk("r1_reg", bus.writeReg, 9);
        chk("r1_data", bus.writeData, 32'h99);
        tick();

        // Contention: {2,B} vs {3,C}
        bus.req0Valid = 1'b1; bus.req0Reg = 5'd2; bus.req0Data = 32'hB;
        bus.req1Valid = 1'b1; bus.req1Reg = 5'd3; bus.req1Data = 32'hC;
        tick();
        bus.req0Valid = 1'b0; bus.req1Valid = 1'b0;
        chk("cont_mask", bus.pendingMask, 32'hC);
        tick();
        chk("cont_a_rw", bus.regWrite, 1);
        chk("cont_a_reg", bus.writeReg, 2);
        chk("cont_a_data", bus.writeData, 32'hB);
        chk("cont_a_mask", bus.pendingMask, 32'hC);
        tick();
        chk("cont_b_rw", bus.regWrite, 1);
        chk("cont_b_reg", bus.writeReg, 3);
        chk("cont_b_data", bus.writeData, 32'hC);
        chk("cont_b_mask", bus.pendingMask, 32'h8);
        tick();
        chk("cont_idle", bus.regWrite, 0);

        // Second pair {4,1} vs {5,2}
        bus.req0Valid = 1'b1; bus.req0Reg = 5'd4; bus.req0Data = 32'h1;
        bus.req1Valid = 1'b1; bus.req1Reg = 5'd5; bus.req1Data = 32'h2;
        tick();
        bus.req0Valid = 1'b0; bus.req1Valid = 1'b0;
        tick();
        chk("cont2_a_reg", bus.writeReg, 4);
        chk("cont2_a_data", bus.writeData, 32'h1);
        tick();
        chk("cont2_b_reg", bus.writeReg, 5);
        chk("cont2_b_data", bus.writeData, 32'h2);
        tick();

        // Register 0 write is consumed silently
        bus.req0Valid = 1'b1; bus.req0Reg = 5'd0; bus.req0Data = 32'hC;
        #1;
        chk("r0_ready", bus.req0Ready, 1);
        tick();
        bus.req0Valid = 1'b0;
        chk("r0_mask", bus.pendingMask, 0);
        chk("r0_busy", bus.busy, 0);
        chk("r0_rw_a", bus.regWrite, 0);
        tick();
        chk("r0_rw_b", bus.regWrite, 0);

        // Backpressure: both requesters backlogged, regs 1..6, data = reg*16
        i0 = 0;
        i1 = 0;
        for (int e = 0; e < 8; e++) begin
            bus.req0Valid = (i0 < 3);
            bus.req0Reg   = 5'(r0_regs[(i0 < 3) ? i0 : 0]);
            bus.req0Data  = r0_regs[(i0 < 3) ? i0 : 0] << 4;
            bus.req1Valid = (i1 < 3);
            bus.req1Reg   = 5'(r1_regs[(i1 < 3) ? i1 : 0]);
            bus.req1Data  = r1_regs[(i1 < 3) ? i1 : 0] << 4;
            #1;
            acc0 = bus.req0Valid && bus.req0Ready;
            acc1 = bus.req1Valid && bus.req1Ready;
            tick();
            if (acc0) i0++;
            if (acc1) i1++;
            chk($sformatf("bp_rw_%0d", e), bus.regWrite, exp_rw[e]);
            if (exp_rw[e] == 1) begin
                chk($sformatf("bp_reg_%0d", e), bus.writeReg, exp_reg[e]);
                chk($sformatf("bp_data_%0d", e), bus.writeData, exp_reg[e] << 4);
            end
            if (e == 1) chk("bp_ready1_full", bus.req1Ready, 0);
            if (e == 2) chk("bp_ready0_full", bus.req0Ready, 0);
            if (e == 3) chk("bp_ready1_full2", bus.req1Ready, 0);
        end
        bus.req0Valid = 1'b0;
        bus.req1Valid = 1'b0;
        chk("bp_all_taken0", 32'(i0), 3);
        chk("bp_all_taken1", 32'(i1), 3);
        chk("bp_mask_end", bus.pendingMask, 0);

        // Mid-operation reset with two entries buffered in requester 1
        bus.req0Valid = 1'b1; bus.req0Reg = 5'd12; bus.req0Data = 32'h12;
        bus.req1Valid = 1'b1; bus.req1Reg = 5'd10; bus.req1Data = 32'h10;
        tick();
        bus.req0Reg = 5'd13; bus.req0Data = 32'h13;
        bus.req1Reg = 5'd11; bus.req1Data = 32'h11;
        tick();
        bus.req0Valid = 1'b0; bus.req1Valid = 1'b0;
        chk("mid_rw", bus.regWrite, 1);
        chk("mid_reg", bus.writeReg, 12);
        chk("mid_mask", bus.pendingMask, 32'h3C00);
        chk("mid_ready1", bus.req1Ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_rw", bus.regWrite, 0);
        chk("arst_reg", bus.writeReg, 0);
        chk("arst_data", bus.writeData, 0);
        chk("arst_mask", bus.pendingMask, 0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_ready0", bus.req0Ready, 0);
        chk("arst_ready1", bus.req1Ready, 0);
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("post_rst_rw_%0d", k), bus.regWrite, 0);
        end
        chk("post_rst_mask", bus.pendingMask, 0);
        chk("post_rst_busy", bus.busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
